// File: rtl/data_cache_pkg.sv
// rtl/data_cache_pkg.sv - address field widths, block width and FSM states for data_cache
package data_cache_pkg;
  localparam int TAG_W      = 3;
  localparam int INDEX_W    = 3;
  localparam int OFFSET_W   = 2;
  localparam int ADDR_W     = TAG_W + INDEX_W + OFFSET_W;
  localparam int MEM_ADDR_W = TAG_W + INDEX_W;
  localparam int BLOCK_W    = 32;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITEBACK = 2'd1,
    ST_FETCH     = 2'd2
  } cache_state_e;
endpackage

// File: rtl/data_cache_fsm.sv
// rtl/data_cache_fsm.sv - miss-handling FSM: state register, memory handshake and CPU stall
module data_cache_fsm
  import data_cache_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  read,
  input  logic                  write,
  input  logic                  hit,
  input  logic                  victim_dirty,
  input  logic [TAG_W-1:0]      req_tag,
  input  logic [TAG_W-1:0]      victim_tag,
  input  logic [INDEX_W-1:0]    index,
  input  logic [BLOCK_W-1:0]    victim_data,
  input  logic                  mem_busywait,
  output logic                  busywait,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [MEM_ADDR_W-1:0] mem_address,
  output logic [BLOCK_W-1:0]    mem_writedata,
  output logic                  fill_en
);
  cache_state_e state_q, state_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    busywait      = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_address   = '0;
    mem_writedata = '0;
    fill_en       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if ((read || write) && !hit) begin
          busywait = 1'b1;
          state_d  = victim_dirty ? ST_WRITEBACK : ST_FETCH;
        end
      end
      ST_WRITEBACK: begin
        busywait      = 1'b1;
        mem_write     = 1'b1;
        mem_address   = {victim_tag, index};
        mem_writedata = victim_data;
        if (!mem_busywait) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        busywait    = 1'b1;
        mem_read    = 1'b1;
        mem_address = {req_tag, index};
        if (!mem_busywait) begin
          fill_en = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A held request must not keep the CPU stalled while reset is asserted.
    if (rst) busywait = 1'b0;
  end
endmodule

// File: rtl/data_cache.sv
// rtl/data_cache.sv - direct-mapped write-back data cache: line arrays, hit compare, byte select
module data_cache
  import data_cache_pkg::*;
#(
  parameter int NUM_BLOCKS  = 8,
  parameter int BLOCK_BYTES = 4
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  READ,
  input  logic                  WRITE,
  input  logic [ADDR_W-1:0]     ADDRESS,
  input  logic [7:0]            WRITEDATA,
  output logic [7:0]            READDATA,
  output logic                  BUSYWAIT,
  output logic                  MEM_READ,
  output logic                  MEM_WRITE,
  output logic [MEM_ADDR_W-1:0] MEM_ADDRESS,
  output logic [BLOCK_W-1:0]    MEM_WRITEDATA,
  input  logic [BLOCK_W-1:0]    MEM_READDATA,
  input  logic                  MEM_BUSYWAIT
);
  typedef logic [BLOCK_BYTES-1:0][7:0] line_t;

  logic [TAG_W-1:0]    addr_tag;
  logic [INDEX_W-1:0]  addr_index;
  logic [OFFSET_W-1:0] addr_offset;
  assign {addr_tag, addr_index, addr_offset} = ADDRESS;

  logic [NUM_BLOCKS-1:0] valid_q, valid_d, dirty_q, dirty_d;
  logic [TAG_W-1:0]      tag_q  [NUM_BLOCKS];
  logic [TAG_W-1:0]      tag_d  [NUM_BLOCKS];
  line_t                 data_q [NUM_BLOCKS];
  line_t                 data_d [NUM_BLOCKS];

  logic hit, fill_en, store_hit, load_hit;

  assign hit       = valid_q[addr_index] && (tag_q[addr_index] == addr_tag);
  assign store_hit = WRITE && hit && !BUSYWAIT;
  assign load_hit  = READ && !WRITE && hit && !BUSYWAIT;
  assign READDATA  = load_hit ? data_q[addr_index][addr_offset] : 8'h00;

  data_cache_fsm u_fsm (
    .clk           (CLK),
    .rst           (RESET),
    .read          (READ),
    .write         (WRITE),
    .hit           (hit),
    .victim_dirty  (valid_q[addr_index] && dirty_q[addr_index]),
    .req_tag       (addr_tag),
    .victim_tag    (tag_q[addr_index]),
    .index         (addr_index),
    .victim_data   (data_q[addr_index]),
    .mem_busywait  (MEM_BUSYWAIT),
    .busywait      (BUSYWAIT),
    .mem_read      (MEM_READ),
    .mem_write     (MEM_WRITE),
    .mem_address   (MEM_ADDRESS),
    .mem_writedata (MEM_WRITEDATA),
    .fill_en       (fill_en)
  );

  // A fill and a store hit are mutually exclusive: stores only commit outside a miss.
  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (fill_en) begin
      valid_d[addr_index] = 1'b1;
      dirty_d[addr_index] = 1'b0;
      tag_d[addr_index]   = addr_tag;
      data_d[addr_index]  = MEM_READDATA;
    end else if (store_hit) begin
      dirty_d[addr_index]              = 1'b1;
      data_d[addr_index][addr_offset]  = WRITEDATA;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  always_ff @(posedge CLK) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end
endmodule

// File: tb/tb_data_cache.sv
// tb/tb_data_cache.sv - self-checking bench for data_cache with shadow cache model and memory model
module tb_data_cache;
  localparam int MEM_LAT = 2;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        READ, WRITE;
  logic [7:0]  ADDRESS, WRITEDATA, READDATA;
  logic        BUSYWAIT, MEM_READ, MEM_WRITE;
  logic [5:0]  MEM_ADDRESS;
  logic [31:0] MEM_WRITEDATA;
  logic [31:0] MEM_READDATA;
  logic        MEM_BUSYWAIT;

  int checks = 0;
  int errors = 0;

  data_cache #(.NUM_BLOCKS(8), .BLOCK_BYTES(4)) dut (
    .CLK(CLK), .RESET(RESET), .READ(READ), .WRITE(WRITE), .ADDRESS(ADDRESS),
    .WRITEDATA(WRITEDATA), .READDATA(READDATA), .BUSYWAIT(BUSYWAIT),
    .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDRESS(MEM_ADDRESS),
    .MEM_WRITEDATA(MEM_WRITEDATA), .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Memory: busy by default, drops busy for one cycle MEM_LAT cycles into a request.
  logic [31:0] mem [64];
  int lat;
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + i;
    mem[0] = 32'h4433_2211;
    mem[8] = 32'h8877_6655;
    MEM_BUSYWAIT = 1'b1;
    MEM_READDATA = '0;
    lat = 0;
    forever begin
      @(posedge CLK); #1;
      if (RESET) begin
        MEM_BUSYWAIT = 1'b1;
        lat = 0;
      end else if (!MEM_BUSYWAIT) begin
        MEM_BUSYWAIT = 1'b1;
      end else if (MEM_READ || MEM_WRITE) begin
        lat++;
        if (lat >= MEM_LAT) begin
          lat = 0;
          MEM_BUSYWAIT = 1'b0;
          if (MEM_WRITE) mem[MEM_ADDRESS] = MEM_WRITEDATA;
          else           MEM_READDATA = mem[MEM_ADDRESS];
        end
      end
    end
  end

  // Shadow cache plus the list of block transfers a pending miss still owes.
  typedef struct {
    logic        wr;
    logic [5:0]  addr;
    logic [31:0] data;
  } txn_t;

  logic        m_valid [8];
  logic        m_dirty [8];
  logic [2:0]  m_tag   [8];
  logic [31:0] m_data  [8];
  txn_t        op_q [$];
  txn_t        log_q [$];
  int          mem_req_cycles = 0;

  always @(posedge CLK or posedge RESET) begin : model_blk
    logic [2:0] idx;
    logic       mhit;
    idx  = ADDRESS[4:2];
    mhit = m_valid[idx] && (m_tag[idx] == ADDRESS[7:5]);
    if (RESET) begin
      for (int i = 0; i < 8; i++) begin
        m_valid[i] = 1'b0;
        m_dirty[i] = 1'b0;
      end
      op_q.delete();
    end else if (op_q.size() != 0) begin
      if (!MEM_BUSYWAIT) begin
        if (!op_q[0].wr) begin
          m_valid[op_q[0].addr[2:0]] = 1'b1;
          m_dirty[op_q[0].addr[2:0]] = 1'b0;
          m_tag[op_q[0].addr[2:0]]   = op_q[0].addr[5:3];
          m_data[op_q[0].addr[2:0]]  = mem[op_q[0].addr];
        end
        void'(op_q.pop_front());
      end
    end else if (READ || WRITE) begin
      if (!mhit) begin
        if (m_valid[idx] && m_dirty[idx])
          op_q.push_back('{wr: 1'b1, addr: {m_tag[idx], idx}, data: m_data[idx]});
        op_q.push_back('{wr: 1'b0, addr: {ADDRESS[7:5], idx}, data: 32'h0});
      end else if (WRITE) begin
        m_data[idx][{ADDRESS[1:0], 3'b000} +: 8] = WRITEDATA;
        m_dirty[idx] = 1'b1;
      end
    end
  end

  always @(negedge CLK) begin : compare_blk
    logic [2:0]  idx;
    logic        mhit;
    logic        e_bw, e_mr, e_mw;
    logic [5:0]  e_ma;
    logic [31:0] e_wd;
    logic [7:0]  e_rd;
    idx  = ADDRESS[4:2];
    mhit = m_valid[idx] && (m_tag[idx] == ADDRESS[7:5]);
    e_bw = 1'b0; e_mr = 1'b0; e_mw = 1'b0; e_ma = '0; e_wd = '0; e_rd = '0;
    if (!RESET) begin
      if (op_q.size() != 0) begin
        e_bw = 1'b1;
        e_ma = op_q[0].addr;
        if (op_q[0].wr) begin
          e_mw = 1'b1;
          e_wd = op_q[0].data;
        end else begin
          e_mr = 1'b1;
        end
      end else begin
        e_bw = (READ || WRITE) && !mhit;
        if (READ && !WRITE && mhit) e_rd = m_data[idx][{ADDRESS[1:0], 3'b000} +: 8];
      end
    end
    chk("busywait", BUSYWAIT, e_bw);
    chk("mem_read", MEM_READ, e_mr);
    chk("mem_write", MEM_WRITE, e_mw);
    chk("mem_address", MEM_ADDRESS, e_ma);
    chk("mem_writedata", MEM_WRITEDATA, e_wd);
    chk("readdata", READDATA, e_rd);
    if (MEM_READ || MEM_WRITE) mem_req_cycles++;
    if ((MEM_READ || MEM_WRITE) && !MEM_BUSYWAIT)
      log_q.push_back('{wr: MEM_WRITE, addr: MEM_ADDRESS, data: MEM_WRITEDATA});
  end

  task automatic wait_done(output logic [7:0] rdata, output int stall);
    stall = 0;
    @(negedge CLK);
    while (BUSYWAIT && stall < 50) begin
      stall++;
      @(negedge CLK);
    end
    chk("busywait_timeout", BUSYWAIT, 1'b0);
    rdata = READDATA;
    @(posedge CLK); #1;
    READ  = 1'b0;
    WRITE = 1'b0;
  endtask

  task automatic cpu_op(input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] wd,
                        output logic [7:0] rdata, output int stall);
    READ = rd; WRITE = wr; ADDRESS = a; WRITEDATA = wd;
    wait_done(rdata, stall);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [7:0] rd;
    int st, base, cyc, n;
    RESET = 1'b1; READ = 1'b0; WRITE = 1'b0; ADDRESS = '0; WRITEDATA = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("reset_busywait", BUSYWAIT, 1'b0);
    chk("reset_mem_read", MEM_READ, 1'b0);
    chk("reset_readdata", READDATA, 8'h00);
    @(posedge CLK); #3;
    RESET = 1'b0;

    // Clean miss on an empty cache, then hits in the filled line.
    base = log_q.size();
    cpu_op(1'b1, 1'b0, 8'h00, 8'h00, rd, st);
    chk("first_read_data", rd, 8'h11);
    chk("first_read_stall", st, 1 + MEM_LAT);
    chk("first_fetch_count", log_q.size() - base, 1);
    if (log_q.size() > base) begin
      chk("first_fetch_rw", log_q[base].wr, 1'b0);
      chk("first_fetch_addr", log_q[base].addr, 6'h00);
    end

    cyc = mem_req_cycles;
    cpu_op(1'b1, 1'b0, 8'h03, 8'h00, rd, st);
    chk("hit_read_data", rd, 8'h44);
    chk("hit_read_stall", st, 0);
    cpu_op(1'b0, 1'b1, 8'h01, 8'hAB, rd, st);
    chk("hit_write_stall", st, 0);
    cpu_op(1'b1, 1'b0, 8'h01, 8'h00, rd, st);
    chk("readback_01", rd, 8'hAB);
    chk("no_mem_on_hits", mem_req_cycles - cyc, 0);

    // Dirty conflict miss: write-back of line 0 then fetch of block 0x08.
    base = log_q.size();
    cpu_op(1'b1, 1'b0, 8'h20, 8'h00, rd, st);
    chk("dirty_miss_data", rd, 8'h55);
    chk("dirty_miss_txns", log_q.size() - base, 2);
    if (log_q.size() >= base + 2) begin
      chk("wb_rw", log_q[base].wr, 1'b1);
      chk("wb_addr", log_q[base].addr, 6'h00);
      chk("wb_data", log_q[base].data, 32'h4433_AB11);
      chk("refill_rw", log_q[base+1].wr, 1'b0);
      chk("refill_addr", log_q[base+1].addr, 6'h08);
    end
    chk("wb_mem_updated", mem[0], 32'h4433_AB11);

    // Store miss: write-allocate into index 7.
    base = log_q.size();
    cpu_op(1'b0, 1'b1, 8'h1E, 8'h5C, rd, st);
    chk("store_miss_txns", log_q.size() - base, 1);
    if (log_q.size() > base) chk("store_miss_fetch", log_q[base].addr, 6'h07);
    cpu_op(1'b1, 1'b0, 8'h1E, 8'h00, rd, st);
    chk("readback_1e", rd, 8'h5C);
    chk("readback_1e_stall", st, 0);

    // READ and WRITE together: the store wins and no load data is returned.
    cpu_op(1'b1, 1'b1, 8'h1E, 8'h77, rd, st);
    chk("rw_both_readdata", rd, 8'h00);
    chk("rw_both_stall", st, 0);
    cpu_op(1'b1, 1'b0, 8'h1E, 8'h00, rd, st);
    chk("rw_both_readback", rd, 8'h77);

    // Reset in the middle of a fetch.
    READ = 1'b1; ADDRESS = 8'h00;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!MEM_READ && n < 20);
    chk("fetch_before_reset", MEM_READ, 1'b1);
    #2 RESET = 1'b1;
    #1;
    chk("rst_mid_mem_read", MEM_READ, 1'b0);
    chk("rst_mid_busywait", BUSYWAIT, 1'b0);
    chk("rst_mid_mem_address", MEM_ADDRESS, 6'h00);
    @(posedge CLK); #3;
    RESET = 1'b0;
    base = log_q.size();
    wait_done(rd, st);
    chk("post_reset_stall", st, 1 + MEM_LAT);
    chk("post_reset_data", rd, 8'h11);
    chk("post_reset_txns", log_q.size() - base, 1);

    repeat (3) @(posedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
